// File: rtl/result_capture_if.sv
// Handshake and result bus between the XOR stage, the capture block and the downstream consumer.
interface result_capture_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             start_ready;
  logic [WIDTH-1:0] result_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_parity;

  // Upstream/downstream side: issues starts, supplies the result, accepts output entries.
  modport master (
    output start,
    output result_in,
    output out_ready,
    input  start_ready,
    input  busy,
    input  out_valid,
    input  out_data,
    input  out_zero,
    input  out_parity
  );

  // Capture block side.
  modport slave (
    input  start,
    input  result_in,
    input  out_ready,
    output start_ready,
    output busy,
    output out_valid,
    output out_data,
    output out_zero,
    output out_parity
  );
endinterface

// File: rtl/result_capture.sv
// Waits a fixed number of cycles for a combinational XOR result to settle, samples it once,
// and queues it in a 2-entry FIFO with zero and parity flags on the head entry.
module result_capture #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  result_capture_if.slave bus
);

  typedef enum logic {StIdle, StSettle} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             start_ready;
  logic             accept;
  logic             push;
  logic             pop;

  // Handshake decode: accepted start, end-of-settle push, downstream pop.
  always_comb begin
    start_ready = !reset && (state_q == StIdle) && (count_q != 2'd2);
    accept      = bus.start && start_ready;
    push        = (state_q == StSettle) && (cnt_q == 4'd0);
    pop         = (count_q != 2'd0) && bus.out_ready;
  end

  // Settle FSM: count down SETTLE_CYCLES edges after an accepted start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSettle;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Two-entry FIFO; head_q is always the oldest valid entry.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = bus.result_in;
        end else begin
          tail_d = bus.result_in;
        end
        if (count_q != 2'd2) begin
          count_d = count_q + 2'd1;
        end
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the new entry lands behind whatever survives the pop.
        if (count_q == 2'd1) begin
          head_d = bus.result_in;
        end else begin
          head_d = tail_q;
          tail_d = bus.result_in;
        end
      end
      default: ;
    endcase
  end

  // State registers, cleared asynchronously so an in-flight capture is abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Outputs; data and flags are masked to zero whenever the FIFO is empty.
  always_comb begin
    bus.start_ready = start_ready;
    bus.busy        = (state_q == StSettle);
    bus.out_valid   = (count_q != 2'd0);
    bus.out_data    = (count_q != 2'd0) ? head_q : '0;
    bus.out_zero    = (count_q != 2'd0) && (head_q == '0);
    bus.out_parity  = (count_q != 2'd0) && (^head_q);
  end

endmodule
